prbs_gen_chk: RTL and testbench



---
 rtl/prbs_gen_chk.sv | 184 ++++++++++++++++++
 tb/tb_prbs_gen_chk.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_gen_chk.sv
`timescale 1ns/1ps
// prbs_gen_chk
// PRBS pattern generator plus self-synchronising checker with run-time
// selection of PRBS7/15/23/31. The generator emits one registered bit per
// enabled cycle. The checker predicts each incoming bit from the bits it
// has already received, locks after a run of clean bits, and then counts
// mismatches into a saturating error counter.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   en          generator advance enable
//   mode[1:0]   00 PRBS7, 01 PRBS15, 10 PRBS23, 11 PRBS31
//   inject_err  inverts the generator output bit of an enabled cycle
//   gen_out     registered generator bit
//   rx_in       serial bit under test
//   rx_valid    qualifies rx_in
//   clr_cnt     clears err_cnt and err_sat
//   locked      checker is in LOCKED
//   err_cnt     mismatches counted while locked, saturating
//   err_sat     sticky, err_cnt has reached all ones
//
// Checker states
//   state     | meaning
//   ST_SEARCH | counting consecutive matching bits, no errors counted
//   ST_LOCKED | counting errors, per-128-bit window unlock monitor
module prbs_gen_chk #(
   parameter int CNT_W      = 16,
   parameter int LOCK_CNT   = 32,
   parameter int UNLOCK_ERR = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             inject_err,
   output logic             gen_out,
   input  logic             rx_in,
   input  logic             rx_valid,
   input  logic             clr_cnt,
   output logic             locked,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err_sat
);

   typedef enum logic [0:0] {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int WERR_W  = $clog2(UNLOCK_ERR + 1);
   localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
   localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(UNLOCK_ERR - 1);
   localparam logic [6:0]         WIN_LAST   = 7'd127;

   // XOR of the two tap bits (N-1, M-1) for the selected polynomial
   function automatic logic tap_xor(input logic [30:0] v, input logic [1:0] m);
      logic t;
      case (m)
         2'b00:   t = v[6]  ^ v[5];
         2'b01:   t = v[14] ^ v[13];
         2'b10:   t = v[22] ^ v[17];
         default: t = v[30] ^ v[27];
      endcase
      return t;
   endfunction

   logic [30:0]        lfsr;
   logic [30:0]        chk_sr;
   logic [1:0]         mode_q;
   state_t             state;
   logic [MATCH_W-1:0] match_cnt;
   logic [6:0]         win_cnt;
   logic [WERR_W-1:0]  win_err;

   logic gen_fb;
   logic pred;
   logic mis;
   logic mode_chg;
   logic err_hit;

   always_comb begin
      gen_fb   = tap_xor(lfsr, mode);
      pred     = tap_xor(chk_sr, mode);
      mis      = (rx_in != pred);
      mode_chg = (mode != mode_q);
      // a mode-change edge resets the checker, so it never counts an error
      err_hit  = rx_valid && mis && (state == ST_LOCKED) && !mode_chg;
   end

   // generator; a mode change reseeds instead of advancing
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr    <= '1;
         gen_out <= 1'b0;
         mode_q  <= mode;
      end else begin
         mode_q <= mode;
         if (mode_chg) begin
            lfsr <= '1;
         end else if (en) begin
            lfsr    <= {lfsr[29:0], gen_fb};
            // inversion only on the output so the LFSR stays on-sequence
            gen_out <= gen_fb ^ inject_err;
         end
      end
   end

   // checker shift register and lock FSM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         chk_sr    <= '0;
         state     <= ST_SEARCH;
         locked    <= 1'b0;
         match_cnt <= '0;
         win_cnt   <= '0;
         win_err   <= '0;
      end else begin
         if (rx_valid) begin
            chk_sr <= {chk_sr[29:0], rx_in};
         end
         if (mode_chg) begin
            state     <= ST_SEARCH;
            locked    <= 1'b0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
         end else if (rx_valid) begin
            case (state)
               ST_SEARCH: begin
                  if (mis) begin
                     match_cnt <= '0;
                  end else if (match_cnt == MATCH_LAST) begin
                     state     <= ST_LOCKED;
                     locked    <= 1'b1;
                     match_cnt <= '0;
                     win_cnt   <= '0;
                     win_err   <= '0;
                  end else begin
                     match_cnt <= match_cnt + MATCH_W'(1);
                  end
               end
               ST_LOCKED: begin
                  // the error that reaches the threshold is the last one counted
                  if (mis && (win_err == WERR_LAST)) begin
                     state     <= ST_SEARCH;
                     locked    <= 1'b0;
                     match_cnt <= '0;
                     win_cnt   <= '0;
                     win_err   <= '0;
                  end else begin
                     win_cnt <= win_cnt + 7'd1;
                     if (win_cnt == WIN_LAST) begin
                        win_err <= '0;
                     end else begin
                        win_err <= win_err + WERR_W'(mis);
                     end
                  end
               end
               default: begin
                  state  <= ST_SEARCH;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

   // saturating error counter; clear wins over a same-cycle error
   always_ff @(posedge clk) begin
      if (!rst_n || clr_cnt) begin
         err_cnt <= '0;
         err_sat <= 1'b0;
      end else if (err_hit && (err_cnt != CNT_MAX)) begin
         err_cnt <= err_cnt + CNT_W'(1);
         if (err_cnt == (CNT_MAX - CNT_W'(1))) begin
            err_sat <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_prbs_gen_chk.sv
`timescale 1ns/1ps
module tb_prbs_gen_chk;

   localparam int LOCK_CNT   = 32;
   localparam int UNLOCK_ERR = 8;
   localparam int WIN        = 128;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [1:0]  mode;
   logic        inject_err;
   logic        rx_in;
   logic        rx_valid;
   logic        clr_cnt;

   logic        gen_out,  locked,  err_sat;
   logic [15:0] err_cnt;
   logic        gen_out4, locked4, err_sat4;
   logic [3:0]  err_cnt4;

   always #5 clk = ~clk;

   prbs_gen_chk dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inject_err(inject_err),
      .gen_out(gen_out), .rx_in(rx_in), .rx_valid(rx_valid), .clr_cnt(clr_cnt),
      .locked(locked), .err_cnt(err_cnt), .err_sat(err_sat)
   );

   prbs_gen_chk #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inject_err(inject_err),
      .gen_out(gen_out4), .rx_in(rx_in), .rx_valid(rx_valid), .clr_cnt(clr_cnt),
      .locked(locked4), .err_cnt(err_cnt4), .err_sat(err_sat4)
   );

   // reference model: bit histories (oldest first, 31 deep) and plain counters
   bit         gh[$];
   bit         rh[$];
   bit         m_gen, m_locked, m_sat16, m_sat4;
   int         m_match, m_wpos, m_werr, m_err16, m_err4;
   logic [1:0] m_mode_q;

   int n_checks = 0;
   int n_bad    = 0;

   function automatic int tap_n(input logic [1:0] m);
      case (m)
         2'b00:   return 7;
         2'b01:   return 15;
         2'b10:   return 23;
         default: return 31;
      endcase
   endfunction

   function automatic int tap_m(input logic [1:0] m);
      case (m)
         2'b00:   return 6;
         2'b01:   return 14;
         2'b10:   return 18;
         default: return 28;
      endcase
   endfunction

   task automatic model_reset();
      gh.delete();
      rh.delete();
      for (int i = 0; i < 31; i++) begin
         gh.push_back(1'b1);
         rh.push_back(1'b0);
      end
      m_gen    = 1'b0;
      m_locked = 1'b0;
      m_match  = 0;
      m_wpos   = 0;
      m_werr   = 0;
      m_err16  = 0;
      m_err4   = 0;
      m_sat16  = 1'b0;
      m_sat4   = 1'b0;
      m_mode_q = mode;
   endtask

   task automatic model_step();
      int n, mt;
      bit chg, pred, mis, hit, fb;
      if (!rst_n) begin
         model_reset();
         return;
      end
      n    = tap_n(mode);
      mt   = tap_m(mode);
      chg  = (mode != m_mode_q);
      // x[k] = x[k-N] ^ x[k-M] over the received history
      pred = rh[31-n] ^ rh[31-mt];
      mis  = (rx_in != pred);
      hit  = 1'b0;
      if (chg) begin
         for (int i = 0; i < 31; i++) gh[i] = 1'b1;
      end else if (en) begin
         fb = gh[31-n] ^ gh[31-mt];
         gh.push_back(fb);
         void'(gh.pop_front());
         m_gen = fb ^ inject_err;
      end
      if (rx_valid) begin
         rh.push_back(rx_in);
         void'(rh.pop_front());
      end
      if (chg) begin
         m_locked = 1'b0; m_match = 0; m_wpos = 0; m_werr = 0;
      end else if (rx_valid) begin
         if (!m_locked) begin
            m_match = mis ? 0 : m_match + 1;
            if (m_match == LOCK_CNT) begin
               m_locked = 1'b1; m_match = 0; m_wpos = 0; m_werr = 0;
            end
         end else begin
            if (mis) begin
               hit = 1'b1;
               m_werr++;
            end
            if (m_werr >= UNLOCK_ERR) begin
               m_locked = 1'b0; m_match = 0; m_wpos = 0; m_werr = 0;
            end else begin
               m_wpos++;
               if (m_wpos == WIN) begin
                  m_wpos = 0;
                  m_werr = 0;
               end
            end
         end
      end
      if (clr_cnt) begin
         m_err16 = 0; m_sat16 = 1'b0; m_err4 = 0; m_sat4 = 1'b0;
      end else if (hit) begin
         if (m_err16 < 65535) m_err16++;
         if (m_err16 == 65535) m_sat16 = 1'b1;
         if (m_err4 < 15) m_err4++;
         if (m_err4 == 15) m_sat4 = 1'b1;
      end
      m_mode_q = mode;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      logic [25:0] act_v, exp_v;
      @(posedge clk);
      model_step();
      #1;
      act_v = {gen_out, locked, gen_out4, locked4, err_sat, err_sat4, err_cnt4, err_cnt};
      exp_v = {m_gen, m_locked, m_gen, m_locked, m_sat16, m_sat4, m_err4[3:0], m_err16[15:0]};
      check("outputs", 32'(act_v), 32'(exp_v));
   endtask

   // loopback drive: rx sees the generator bit currently on gen_out
   task automatic cyc(input bit e, input bit inj, input bit clr);
      en         = e;
      inject_err = inj;
      rx_valid   = e;
      rx_in      = m_gen;
      clr_cnt    = clr;
      tick();
   endtask

   task automatic wait_locked(input string name, input int budget);
      int i = 0;
      while (!m_locked && i < budget) begin
         cyc(1'b1, 1'b0, 1'b0);
         i++;
      end
      check(name, 32'(locked), 32'd1);
   endtask

   typedef struct {
      bit e;
      bit inj;
      bit exp_gen;
   } vec_t;

   vec_t tbl[10];
   bit   seq7[7];
   bit   bits[254];

   initial begin
      int ones, diffs, guard;

      // PRBS7 from all-ones seed, with hold and injection rows
      tbl[0] = '{1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 1'b0};
      tbl[6] = '{1'b1, 1'b1, 1'b1};
      tbl[7] = '{1'b1, 1'b0, 1'b1};
      tbl[8] = '{1'b1, 1'b0, 1'b0};
      tbl[9] = '{1'b0, 1'b0, 1'b0};
      seq7   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      rst_n = 1'b0; mode = 2'b00; en = 1'b0; inject_err = 1'b0;
      rx_in = 1'b0; rx_valid = 1'b0; clr_cnt = 1'b0;
      model_reset();

      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      check("reset_state", 32'({gen_out, locked, err_sat, err_cnt, err_sat4, err_cnt4}), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         cyc(tbl[i].e, tbl[i].inj, 1'b0);
         check($sformatf("tbl_gen[%0d]", i), 32'(gen_out), 32'(tbl[i].exp_gen));
      end

      rst_n = 1'b0; cyc(1'b0, 1'b0, 1'b0); rst_n = 1'b1;
      for (int i = 0; i < 254; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         bits[i] = gen_out;
      end
      ones  = 0;
      diffs = 0;
      for (int i = 0; i < 127; i++) begin
         ones  += int'(bits[i]);
         diffs += int'(bits[i] != bits[i+127]);
      end
      check("prbs7_ones", 32'(ones), 32'd64);
      check("prbs7_period_diffs", 32'(diffs), 32'd0);

      for (int m = 0; m < 4; m++) begin
         mode = m[1:0];
         rst_n = 1'b0; cyc(1'b0, 1'b0, 1'b0); rst_n = 1'b1;
         for (int i = 0; i < 10000; i++)
            cyc($urandom_range(0, 7) != 0, 1'b0, 1'b0);
         check($sformatf("lock_mode%0d", m), 32'(locked), 32'd1);
         check($sformatf("clean_errs_mode%0d", m), 32'(err_cnt), 32'd0);
      end

      // single injected bit in locked PRBS31 -> three mismatches
      cyc(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 200; i++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 60; i++) cyc(1'b1, 1'b0, 1'b0);
      check("single_inject_errs", 32'(err_cnt), 32'd3);
      check("single_inject_locked", 32'(locked), 32'd1);

      // three pulses 40 bits apart inside one window force an unlock
      for (int i = 0; i < 140; i++) cyc(1'b1, 1'b0, 1'b0);
      guard = 0;
      while (m_wpos != 2 && guard < 200) begin
         cyc(1'b1, 1'b0, 1'b0);
         guard++;
      end
      if (guard >= 200) begin
         n_checks++; n_bad++;
         $display("FAIL win_align: timeout after %0d cycles", guard);
      end
      cyc(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 120; i++) cyc(1'b1, (i % 40) == 0, 1'b0);
      check("burst_unlocked", 32'(locked), 32'd0);
      wait_locked("burst_relock", 200);

      // saturation in the 4-bit instance; 64-bit spacing keeps each window below threshold
      cyc(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 6 * 64 + 40; i++) cyc(1'b1, (i % 64) == 0 && i < 384, 1'b0);
      check("sat4_cnt", 32'(err_cnt4), 32'd15);
      check("sat4_flag", 32'(err_sat4), 32'd1);
      check("sat4_locked", 32'(locked), 32'd1);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
      check("clr_wins_cnt4", 32'({err_sat4, err_cnt4}), 32'd0);
      check("clr_wins_cnt16", 32'({err_sat, err_cnt}), 32'd0);

      // randomized traffic with sporadic injections and clears
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 7) != 0, $urandom_range(0, 299) == 0, $urandom_range(0, 699) == 0);

      // mode switch 11 -> 00 reseeds the generator and drops lock
      wait_locked("pre_switch_lock", 400);
      mode = 2'b00;
      cyc(1'b1, 1'b0, 1'b0);
      check("switch_unlocked", 32'(locked), 32'd0);
      for (int i = 0; i < 7; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         check($sformatf("switch_seq[%0d]", i), 32'(gen_out), 32'(seq7[i]));
      end
      wait_locked("prbs7_lock", 400);

      // one-edge reset mid-lock
      rst_n = 1'b0;
      cyc(1'b1, 1'b1, 1'b0);
      check("midlock_reset", 32'({gen_out, locked, err_sat, err_cnt, err_sat4, err_cnt4}), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         check($sformatf("post_reset_seq[%0d]", i), 32'(gen_out), 32'(seq7[i]));
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
